// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM encodings and the instruction fields
// that decide whether an operand byte follows the instruction word.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StFetchHi   = 2'd0,
    StFetchLo   = 2'd1,
    StFetchData = 2'd2,
    StHold      = 2'd3
  } fetch_state_e;

  localparam int unsigned ONE_ARG_BIT = 15;
  localparam int unsigned SRC_MSB     = 10;
  localparam int unsigned SRC_LSB     = 9;
  localparam logic [1:0]  SRC_DATA    = 2'b01;

  // True when the instruction takes a data-sourced operand byte.
  function automatic logic needs_data(input logic [15:0] inst);
    return inst[ONE_ARG_BIT] && (inst[SRC_MSB:SRC_LSB] == SRC_DATA);
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage: load has priority over increment, and the
// increment wraps modulo 2^ADDR_W.
module fetch_pc #(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;

  // PC register: redirect wins, otherwise step past each accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_addr;
    end else if (inc) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads a 16-bit instruction high byte first over an 8-bit
// memory port, optionally one operand byte, then holds {inst, data} for the decoder
// until consumed. Define FETCH_INST_PC_EN to add the inst_pc port and register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
`ifdef FETCH_INST_PC_EN
  output logic [ADDR_W-1:0] inst_pc,
`endif
  output logic [15:0]       inst,
  output logic [7:0]        data,
  output logic              inst_valid,
  input  logic              inst_ready
);

  fetch_state_e      state_q, state_d;
  logic [15:0]       inst_q, inst_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] pc;
  logic              accept;

  // A byte counts only when requested and not overridden by a redirect.
  assign mem_req  = (state_q != StHold);
  assign accept   = mem_req && mem_ack && !pc_load;
  assign mem_addr = pc;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (accept),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .pc        (pc)
  );

  // Next state and byte capture; a redirect abandons whatever is in flight.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    data_d  = data_q;
    if (pc_load) begin
      state_d = StFetchHi;
    end else begin
      unique case (state_q)
        StFetchHi: begin
          if (mem_ack) begin
            inst_d[15:8] = mem_rdata;
            data_d       = 8'h00;
            state_d      = StFetchLo;
          end
        end
        StFetchLo: begin
          if (mem_ack) begin
            inst_d[7:0] = mem_rdata;
            state_d     = needs_data({inst_q[15:8], mem_rdata}) ? StFetchData : StHold;
          end
        end
        StFetchData: begin
          if (mem_ack) begin
            data_d  = mem_rdata;
            state_d = StHold;
          end
        end
        StHold: begin
          if (inst_ready) begin
            state_d = StFetchHi;
          end
        end
        default: state_d = StFetchHi;
      endcase
    end
  end

  // FSM and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetchHi;
      inst_q  <= 16'h0000;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
    end
  end

`ifdef FETCH_INST_PC_EN
  logic [ADDR_W-1:0] inst_pc_q;

  // Latch the high-byte address so it stays stable through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_pc_q <= RESET_PC;
    end else if (accept && (state_q == StFetchHi)) begin
      inst_pc_q <= pc;
    end
  end

  assign inst_pc = inst_pc_q;
`endif

  assign inst       = inst_q;
  assign data       = data_q;
  assign inst_valid = (state_q == StHold);

endmodule
